window_cost_accumulator: RTL

- Parametrised successor to the single-row 6-pixel SSD engine in the stereo matcher.
- Takes one left/right row segment per valid beat and computes the per-row SSD or SAD in a 2-stage registered pipeline.
- Accumulates ROWS consecutive beats into one block-matching window cost.
- Emits the cost with a one-cycle valid pulse and a caller-supplied disparity tag, for the downstream disparity-min selector.

---
 rtl/window_cost_accumulator_if.sv | 31 +++
 rtl/window_cost_accumulator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/window_cost_accumulator_if.sv
// Row-segment input and window-cost output bundle for window_cost_accumulator.
// valid_in marks a beat and has no ready: every valid beat is consumed. cost_valid is a one-cycle pulse with no backpressure.
interface window_cost_accumulator_if #(
    parameter int PIXELS  = 6,
    parameter int PIXEL_W = 8,
    parameter int ROWS    = 6,
    parameter int TAG_W   = 6
);
    localparam int COST_W = $clog2(ROWS * PIXELS * (2**PIXEL_W - 1)**2 + 1);

    logic [PIXELS*PIXEL_W-1:0] left_row;
    logic [PIXELS*PIXEL_W-1:0] right_row;
    logic                      valid_in;
    logic                      mode_sad_in;
    logic [TAG_W-1:0]          tag_in;
    logic                      abort_in;
    logic [COST_W-1:0]         cost_out;
    logic [TAG_W-1:0]          tag_out;
    logic                      cost_valid;
    logic                      busy;

    modport master (
        output left_row, right_row, valid_in, mode_sad_in, tag_in, abort_in,
        input  cost_out, tag_out, cost_valid, busy
    );

    modport slave (
        input  left_row, right_row, valid_in, mode_sad_in, tag_in, abort_in,
        output cost_out, tag_out, cost_valid, busy
    );
endinterface

// File: rtl/window_cost_accumulator.sv
// Block-matching window cost: per-row SSD/SAD in two registered stages, then
// ROWS rows are summed into one tagged cost emitted as a one-cycle pulse.
module window_cost_accumulator #(
    parameter int PIXELS  = 6,
    parameter int PIXEL_W = 8,
    parameter int ROWS    = 6,
    parameter int TAG_W   = 6
) (
    input logic clk_in,
    input logic rst_n_in,
    window_cost_accumulator_if.slave bus
);
    localparam int COST_W    = $clog2(ROWS * PIXELS * (2**PIXEL_W - 1)**2 + 1);
    localparam int ROW_CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(ROWS - 1);

    function automatic logic [PIXEL_W-1:0] abs_diff_f(input logic [PIXEL_W-1:0] a,
                                                      input logic [PIXEL_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [COST_W-1:0] pixel_term(input logic [PIXEL_W-1:0] d,
                                                     input logic sad);
        logic [2*PIXEL_W-1:0] w;
        w = {{PIXEL_W{1'b0}}, d};
        return sad ? COST_W'(w) : COST_W'(w * w);
    endfunction

    // Input row counter and per-window mode/tag capture
    logic [ROW_CNT_W-1:0] in_row;
    logic                 mode_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 first;
    logic                 last;
    logic                 beat;
    logic                 beat_mode;
    logic [TAG_W-1:0]     beat_tag;

    assign beat      = bus.valid_in & ~bus.abort_in;
    assign first     = (in_row == '0);
    assign last      = (in_row == LAST_ROW);
    assign beat_mode = first ? bus.mode_sad_in : mode_q;
    assign beat_tag  = first ? bus.tag_in : tag_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_row <= '0;
            mode_q <= 1'b0;
            tag_q  <= '0;
        end else if (bus.abort_in) begin
            in_row <= '0;
        end else if (bus.valid_in) begin
            in_row <= last ? '0 : in_row + 1'b1;
            if (first) begin
                mode_q <= bus.mode_sad_in;
                tag_q  <= bus.tag_in;
            end
        end
    end

    // Stage 1: per-pixel absolute difference, pixel 0 taken from the MSBs
    logic [PIXEL_W-1:0] abs_diff [PIXELS];
    logic [PIXEL_W-1:0] s1_diff  [PIXELS];
    logic               s1_valid, s1_first, s1_last, s1_mode;
    logic [TAG_W-1:0]   s1_tag;

    always_comb begin
        for (int i = 0; i < PIXELS; i++) begin
            abs_diff[i] = abs_diff_f(bus.left_row[(PIXELS-1-i)*PIXEL_W +: PIXEL_W],
                                     bus.right_row[(PIXELS-1-i)*PIXEL_W +: PIXEL_W]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_tag   <= '0;
            for (int i = 0; i < PIXELS; i++) s1_diff[i] <= '0;
        end else begin
            s1_valid <= beat;
            if (beat) begin
                s1_first <= first;
                s1_last  <= last;
                s1_mode  <= beat_mode;
                s1_tag   <= beat_tag;
                for (int i = 0; i < PIXELS; i++) s1_diff[i] <= abs_diff[i];
            end
        end
    end

    // Stage 2: row sum widened to the full cost width so it cannot overflow
    logic [COST_W-1:0] row_sum_c;
    logic [COST_W-1:0] s2_row_sum;
    logic              s2_valid, s2_first, s2_last;
    logic [TAG_W-1:0]  s2_tag;

    always_comb begin
        row_sum_c = '0;
        for (int i = 0; i < PIXELS; i++) begin
            row_sum_c = row_sum_c + pixel_term(s1_diff[i], s1_mode);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid   <= 1'b0;
            s2_first   <= 1'b0;
            s2_last    <= 1'b0;
            s2_tag     <= '0;
            s2_row_sum <= '0;
        end else begin
            s2_valid <= s1_valid & ~bus.abort_in;
            if (s1_valid) begin
                s2_first   <= s1_first;
                s2_last    <= s1_last;
                s2_tag     <= s1_tag;
                s2_row_sum <= row_sum_c;
            end
        end
    end

    // Stage 3: window accumulator and output registers
    logic [COST_W-1:0] acc;
    logic [COST_W-1:0] acc_sum;
    logic [COST_W-1:0] cost_q;
    logic [TAG_W-1:0]  tag_out_q;
    logic              cost_valid_q;

    assign acc_sum = s2_first ? s2_row_sum : acc + s2_row_sum;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc          <= '0;
            cost_q       <= '0;
            tag_out_q    <= '0;
            cost_valid_q <= 1'b0;
        end else if (bus.abort_in) begin
            acc          <= '0;
            cost_valid_q <= 1'b0;
        end else begin
            cost_valid_q <= 1'b0;
            if (s2_valid) begin
                acc <= acc_sum;
                if (s2_last) begin
                    cost_q       <= acc_sum;
                    tag_out_q    <= s2_tag;
                    cost_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cost_out   = cost_q;
    assign bus.tag_out    = tag_out_q;
    assign bus.cost_valid = cost_valid_q;
    assign bus.busy       = (in_row != '0) | s1_valid | s2_valid;
endmodule
